// File: rtl/memoria_dados_es.sv
// rtl/memoria_dados_es.sv - data-side responder: clearable RAM plus output/input byte ports
// Loads are combinational; Pronto drops to hold the core on a full output port or an empty input port.
module memoria_dados_es #(
   parameter logic [7:0] IO_BASE        = 8'hFC,
   parameter bit         CLEAR_ON_RESET = 1'b1
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       MemRead,
   input  logic       MemWrite,
   input  logic [7:0] EnderecoDados,
   input  logic [7:0] DadoEscrito,
   output logic [7:0] DadoLido,
   output logic       Pronto,
   output logic [7:0] PortaSaida,
   output logic       SaidaValida,
   input  logic       SaidaAceita,
   input  logic [7:0] PortaEntrada,
   input  logic       EntradaValida,
   output logic       EntradaPronta
);

   typedef enum logic {LIMPANDO, OCIOSO} estado_t;

   localparam estado_t    ESTADO_INICIAL = CLEAR_ON_RESET ? LIMPANDO : OCIOSO;
   localparam logic [7:0] END_SAIDA      = IO_BASE;
   localparam logic [7:0] END_STATUS     = IO_BASE + 8'd1;
   localparam logic [7:0] END_ENTRADA    = IO_BASE + 8'd2;
   localparam logic [7:0] ULTIMO_RAM     = IO_BASE - 8'd1;

   estado_t    estado, proxEstado;
   logic [7:0] cont;
   logic [7:0] ram [0:int'(IO_BASE)-1];
   logic       entradaCheia;
   logic [7:0] entradaBuf;

   logic ativo, ehRam, escritaRam, escritaSaida, pop, push;

   assign ativo        = !Reset && (estado == OCIOSO);
   assign ehRam        = EnderecoDados < IO_BASE;
   assign escritaRam   = ativo && MemWrite && ehRam;
   assign escritaSaida = ativo && MemWrite && (EnderecoDados == END_SAIDA) &&
                         (!SaidaValida || SaidaAceita);
   assign pop          = ativo && MemRead && (EnderecoDados == END_ENTRADA) && entradaCheia;
   assign push         = EntradaValida && EntradaPronta;

   always_ff @(posedge Clock) begin
      if (Reset) estado <= ESTADO_INICIAL;
      else       estado <= proxEstado;
   end

   always_comb begin
      proxEstado = estado;
      if (estado == LIMPANDO && cont == ULTIMO_RAM)
         proxEstado = OCIOSO;
   end

   // EntradaPronta looks only at registered state, so push and pop never coincide.
   always_comb begin
      Pronto        = 1'b0;
      DadoLido      = 8'd0;
      EntradaPronta = 1'b0;
      if (ativo) begin
         Pronto        = 1'b1;
         EntradaPronta = !entradaCheia;
         if (MemWrite && EnderecoDados == END_SAIDA && SaidaValida && !SaidaAceita)
            Pronto = 1'b0;
         if (MemRead) begin
            if (ehRam)
               DadoLido = ram[EnderecoDados];
            else if (EnderecoDados == END_SAIDA)
               DadoLido = PortaSaida;
            else if (EnderecoDados == END_STATUS)
               DadoLido = {6'b0, entradaCheia, SaidaValida};
            else if (EnderecoDados == END_ENTRADA) begin
               if (entradaCheia) DadoLido = entradaBuf;
               else              Pronto   = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         cont         <= 8'd0;
         PortaSaida   <= 8'd0;
         SaidaValida  <= 1'b0;
         entradaCheia <= 1'b0;
         entradaBuf   <= 8'd0;
      end else begin
         if (estado == LIMPANDO)
            cont <= cont + 8'd1;
         if (escritaSaida) begin
            PortaSaida  <= DadoEscrito;
            SaidaValida <= 1'b1;
         end else if (ativo && SaidaValida && SaidaAceita) begin
            SaidaValida <= 1'b0;
         end
         if (pop)
            entradaCheia <= 1'b0;
         if (push) begin
            entradaBuf   <= PortaEntrada;
            entradaCheia <= 1'b1;
         end
      end
   end

   // RAM has no reset; it is zeroed by the clear sweep instead.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         if (estado == LIMPANDO)
            ram[cont] <= 8'd0;
         else if (escritaRam)
            ram[EnderecoDados] <= DadoEscrito;
      end
   end

endmodule

// File: tb/tb_memoria_dados_es.sv
// tb/tb_memoria_dados_es.sv - randomized and directed bench for memoria_dados_es
// Checks the DUT against a memory/port model updated once per clock edge.
module tb_memoria_dados_es;

   logic       Clock = 1'b0;
   logic       Reset, MemRead, MemWrite, SaidaAceita, EntradaValida;
   logic [7:0] EnderecoDados, DadoEscrito, PortaEntrada;
   logic [7:0] DadoLido, PortaSaida;
   logic       Pronto, SaidaValida, EntradaPronta;

   int nVec = 0;
   int nErr = 0;

   logic [7:0] mRam [0:255];
   logic [7:0] mPS, mBuf;
   logic       mSV, mCheia;
   int         mClear;

   memoria_dados_es dut (
      .Clock(Clock), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .EnderecoDados(EnderecoDados), .DadoEscrito(DadoEscrito), .DadoLido(DadoLido),
      .Pronto(Pronto), .PortaSaida(PortaSaida), .SaidaValida(SaidaValida),
      .SaidaAceita(SaidaAceita), .PortaEntrada(PortaEntrada),
      .EntradaValida(EntradaValida), .EntradaPronta(EntradaPronta)
   );

   always #5 Clock = ~Clock;

   function automatic logic expPronto();
      if (Reset || mClear > 0) return 1'b0;
      if (MemWrite && EnderecoDados == 8'hFC && mSV && !SaidaAceita) return 1'b0;
      if (MemRead && EnderecoDados == 8'hFE && !mCheia) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [7:0] expLido();
      if (Reset || mClear > 0 || !MemRead) return 8'd0;
      if (EnderecoDados < 8'hFC) return mRam[EnderecoDados];
      case (EnderecoDados)
         8'hFC:   return mPS;
         8'hFD:   return {6'b0, mCheia, mSV};
         8'hFE:   return mCheia ? mBuf : 8'd0;
         default: return 8'd0;
      endcase
   endfunction

   function automatic logic expEntradaPronta();
      return !Reset && mClear == 0 && !mCheia;
   endfunction

   // Apply the current inputs to the model as the coming edge will.
   task automatic modelEdge();
      logic wOut, pop, push;
      if (Reset) begin
         mClear = 252; mSV = 0; mPS = 0; mCheia = 0; mBuf = 0;
         for (int i = 0; i < 256; i++) mRam[i] = 8'd0;
      end else if (mClear > 0) begin
         mClear--;
      end else begin
         wOut = MemWrite && EnderecoDados == 8'hFC && (!mSV || SaidaAceita);
         pop  = MemRead && EnderecoDados == 8'hFE && mCheia;
         push = EntradaValida && !mCheia;
         if (MemWrite && EnderecoDados < 8'hFC) mRam[EnderecoDados] = DadoEscrito;
         if (wOut) begin mPS = DadoEscrito; mSV = 1'b1; end
         else if (mSV && SaidaAceita) mSV = 1'b0;
         if (pop) mCheia = 1'b0;
         if (push) begin mBuf = PortaEntrada; mCheia = 1'b1; end
      end
   endtask

   task automatic adv();
      modelEdge();
      @(negedge Clock);
   endtask

   task automatic idle();
      Reset = 0; MemRead = 0; MemWrite = 0; SaidaAceita = 0; EntradaValida = 0;
      EnderecoDados = 0; DadoEscrito = 0; PortaEntrada = 0;
   endtask

   task automatic test_reset();
      int n;
      idle(); Reset = 1; MemRead = 1; EnderecoDados = 8'h10;
      #1;
      nVec++; if (Pronto !== 1'b0) begin nErr++; $display("FAIL reset_pronto got %h want 0", Pronto); end
      nVec++; if (DadoLido !== 8'd0) begin nErr++; $display("FAIL reset_lido got %h want 00", DadoLido); end
      adv();
      Reset = 0; n = 0;
      while (n < 400) begin
         #1;
         if (Pronto === 1'b1) break;
         n++;
         adv();
      end
      nVec++; if (n != 252) begin nErr++; $display("FAIL clear_cycles got %0d want 252", n); end
      nVec++; if (SaidaValida !== 1'b0) begin nErr++; $display("FAIL reset_sv got %h want 0", SaidaValida); end
      nVec++; if (EntradaPronta !== 1'b1) begin nErr++; $display("FAIL reset_ep got %h want 1", EntradaPronta); end
      nVec++; if (DadoLido !== 8'd0) begin nErr++; $display("FAIL clear_ram got %h want 00", DadoLido); end
      adv();
   endtask

   task automatic test_ram();
      idle(); MemWrite = 1; EnderecoDados = 8'h20; DadoEscrito = 8'h5C;
      #1;
      nVec++; if (Pronto !== 1'b1) begin nErr++; $display("FAIL ram_wr_pronto got %h want 1", Pronto); end
      adv();
      idle(); MemRead = 1; EnderecoDados = 8'h20;
      #1;
      nVec++; if (DadoLido !== 8'h5C) begin nErr++; $display("FAIL ram_rd got %h want 5c", DadoLido); end
      nVec++; if (Pronto !== 1'b1) begin nErr++; $display("FAIL ram_rd_pronto got %h want 1", Pronto); end
      adv();
      MemWrite = 1; EnderecoDados = 8'h21; DadoEscrito = 8'h77;
      #1;
      nVec++; if (DadoLido !== 8'h00) begin nErr++; $display("FAIL ram_rw_old got %h want 00", DadoLido); end
      adv();
      MemWrite = 0;
      #1;
      nVec++; if (DadoLido !== 8'h77) begin nErr++; $display("FAIL ram_rw_new got %h want 77", DadoLido); end
      adv();
      idle(); MemWrite = 1; EnderecoDados = 8'h10; DadoEscrito = 8'hAA;
      adv();
      idle(); MemRead = 1; EnderecoDados = 8'h10;
      #1;
      nVec++; if (DadoLido !== 8'hAA) begin nErr++; $display("FAIL ram_preload got %h want aa", DadoLido); end
      adv();
   endtask

   task automatic test_output();
      idle(); MemWrite = 1; EnderecoDados = 8'hFC; DadoEscrito = 8'h41;
      #1;
      nVec++; if (Pronto !== 1'b1) begin nErr++; $display("FAIL out_first_pronto got %h want 1", Pronto); end
      adv();
      DadoEscrito = 8'h42;
      #1;
      nVec++; if (PortaSaida !== 8'h41 || SaidaValida !== 1'b1) begin
         nErr++; $display("FAIL out_first got %h/%h want 41/1", PortaSaida, SaidaValida); end
      nVec++; if (Pronto !== 1'b0) begin nErr++; $display("FAIL out_stall got %h want 0", Pronto); end
      adv();
      #1;
      nVec++; if (PortaSaida !== 8'h41) begin nErr++; $display("FAIL out_hold got %h want 41", PortaSaida); end
      SaidaAceita = 1;
      #1;
      nVec++; if (Pronto !== 1'b1) begin nErr++; $display("FAIL out_accept_pronto got %h want 1", Pronto); end
      adv();
      idle(); SaidaAceita = 1;
      #1;
      nVec++; if (PortaSaida !== 8'h42 || SaidaValida !== 1'b1) begin
         nErr++; $display("FAIL out_second got %h/%h want 42/1", PortaSaida, SaidaValida); end
      adv();
      idle();
      #1;
      nVec++; if (SaidaValida !== 1'b0) begin nErr++; $display("FAIL out_drain got %h want 0", SaidaValida); end
      adv();
   endtask

   task automatic test_input();
      idle(); MemRead = 1; EnderecoDados = 8'hFE;
      #1;
      nVec++; if (Pronto !== 1'b0 || DadoLido !== 8'h00) begin
         nErr++; $display("FAIL in_stall got %h/%h want 0/00", Pronto, DadoLido); end
      adv();
      EntradaValida = 1; PortaEntrada = 8'h3E;
      #1;
      nVec++; if (Pronto !== 1'b0) begin nErr++; $display("FAIL in_push_cycle got %h want 0", Pronto); end
      adv();
      EntradaValida = 0; PortaEntrada = 8'h00;
      #1;
      nVec++; if (DadoLido !== 8'h3E || Pronto !== 1'b1) begin
         nErr++; $display("FAIL in_pop got %h/%h want 3e/1", DadoLido, Pronto); end
      adv();
      idle();
      #1;
      nVec++; if (EntradaPronta !== 1'b1) begin nErr++; $display("FAIL in_cleared got %h want 1", EntradaPronta); end
      adv();
   endtask

   task automatic test_status();
      idle(); MemWrite = 1; EnderecoDados = 8'hFC; DadoEscrito = 8'h11;
      EntradaValida = 1; PortaEntrada = 8'h22;
      adv();
      idle(); MemRead = 1; EnderecoDados = 8'hFD;
      #1;
      nVec++; if (DadoLido !== 8'h03) begin nErr++; $display("FAIL status got %h want 03", DadoLido); end
      adv();
      EnderecoDados = 8'hFF;
      #1;
      nVec++; if (DadoLido !== 8'h00 || Pronto !== 1'b1) begin
         nErr++; $display("FAIL reserved got %h/%h want 00/1", DadoLido, Pronto); end
      adv();
      idle(); MemWrite = 1; EnderecoDados = 8'hFD; DadoEscrito = 8'h99;
      #1;
      nVec++; if (Pronto !== 1'b1) begin nErr++; $display("FAIL status_wr_pronto got %h want 1", Pronto); end
      adv();
      idle(); MemRead = 1; EnderecoDados = 8'hFD;
      #1;
      nVec++; if (DadoLido !== 8'h03 || PortaSaida !== 8'h11) begin
         nErr++; $display("FAIL status_wr_ignored got %h/%h want 03/11", DadoLido, PortaSaida); end
      adv();
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 300; i++) begin
         idle();
         r = $urandom_range(0, 9);
         if (r < 4)      EnderecoDados = 8'($urandom_range(0, 7));
         else if (r < 6) EnderecoDados = 8'($urandom_range(8'hF8, 8'hFB));
         else            EnderecoDados = 8'(8'hFC + r - 6);
         MemRead       = 1'($urandom_range(0, 1));
         MemWrite      = 1'($urandom_range(0, 1));
         DadoEscrito   = 8'($urandom);
         SaidaAceita   = ($urandom_range(0, 2) == 0);
         EntradaValida = ($urandom_range(0, 2) == 0);
         PortaEntrada  = 8'($urandom);
         #1;
         nVec++; if (Pronto !== expPronto()) begin
            nErr++; $display("FAIL rnd_pronto[%0d] got %h want %h", i, Pronto, expPronto()); end
         nVec++; if (DadoLido !== expLido()) begin
            nErr++; $display("FAIL rnd_lido[%0d] addr %h got %h want %h", i, EnderecoDados, DadoLido, expLido()); end
         nVec++; if (PortaSaida !== mPS || SaidaValida !== mSV) begin
            nErr++; $display("FAIL rnd_saida[%0d] got %h/%h want %h/%h", i, PortaSaida, SaidaValida, mPS, mSV); end
         nVec++; if (EntradaPronta !== expEntradaPronta()) begin
            nErr++; $display("FAIL rnd_ep[%0d] got %h want %h", i, EntradaPronta, expEntradaPronta()); end
         adv();
      end
   endtask

   task automatic test_reset_stall();
      int n;
      idle(); SaidaAceita = 1;
      adv();
      idle(); MemWrite = 1; EnderecoDados = 8'hFC; DadoEscrito = 8'h5A;
      adv();
      DadoEscrito = 8'h5B;
      #1;
      nVec++; if (Pronto !== 1'b0) begin nErr++; $display("FAIL rst_stall_pre got %h want 0", Pronto); end
      Reset = 1;
      adv();
      Reset = 0; MemWrite = 0;
      #1;
      nVec++; if (SaidaValida !== 1'b0 || PortaSaida !== 8'h00) begin
         nErr++; $display("FAIL rst_stall_out got %h/%h want 0/00", SaidaValida, PortaSaida); end
      n = 0;
      while (n < 400) begin
         #1;
         if (Pronto === 1'b1) break;
         n++;
         adv();
      end
      nVec++; if (n != 252) begin nErr++; $display("FAIL rst_stall_clear got %0d want 252", n); end
      adv();
   endtask

   initial begin
      idle(); Reset = 1;
      modelEdge();
      @(negedge Clock);
      test_reset();
      test_ram();
      test_reset();
      test_output();
      test_input();
      test_status();
      test_random();
      test_reset_stall();
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule

// File: doc/memoria_dados_es.md
Name: memoria_dados_es

Overview:
- Data-side responder for the 8-bit single-cycle core: answers the core's load/store requests on `EnderecoDados`/`DadoEscrito`/`DadoLido`.
- Contains a clearable RAM plus memory-mapped I/O: an output byte port and an input byte port, each with valid/ready handshakes.
- Drives `Pronto`; the top level ANDs it into `PCWrite`, so a blocked I/O access stalls the core until it can complete.

Parameters:
- IO_BASE, 8'hFC, first I/O address; RAM occupies 0..IO_BASE-1.
- CLEAR_ON_RESET, 1, 1 = zero all RAM after reset; 0 = skip the clear phase.

Ports:
- Clock  in  1  system clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- MemRead  in  1  core load request.
- MemWrite  in  1  core store request.
- EnderecoDados  in  8  byte address.
- DadoEscrito  in  8  store data.
- DadoLido  out  8  load data, combinational.
- Pronto  out  1  1 = current access completes this cycle; 0 = core must hold.
- PortaSaida  out  8  output-port data register.
- SaidaValida  out  1  `PortaSaida` holds an unconsumed byte.
- SaidaAceita  in  1  consumer takes the byte when `SaidaValida`=1.
- PortaEntrada  in  8  input-port data from producer.
- EntradaValida  in  1  producer offers `PortaEntrada`.
- EntradaPronta  out  1  = !EntradaCheia; the byte is captured when `EntradaValida` and `EntradaPronta` are both 1.

Behaviour:
- Reset=1 at an edge: state<=LIMPANDO (or OCIOSO if CLEAR_ON_RESET=0), cont<=0, PortaSaida<=0, SaidaValida<=0, EntradaCheia<=0, EntradaBuf<=0.
- During reset: Pronto=0, DadoLido=0.
- Reset mid-clear or mid-stall restarts the clear from cont=0.
- RAM contents survive reset only when CLEAR_ON_RESET=0.
- LIMPANDO:
  - Each cycle: ram[cont]<=0, cont<=cont+1.
  - After writing ram[IO_BASE-1], go to OCIOSO.
  - Takes exactly IO_BASE cycles after Reset falls.
  - Pronto=0, DadoLido=0; core requests and I/O handshakes are ignored (EntradaPronta=0).
- OCIOSO, RAM (addr < IO_BASE):
  - Read is asynchronous: DadoLido=ram[addr] when MemRead=1.
  - Write is at the edge when MemWrite=1.
  - MemRead and MemWrite both high: DadoLido shows the old value; the new value is visible next cycle.
  - Pronto=1.
- DadoLido=0 whenever MemRead=0.
- Address 0xFC (IO_BASE), output data:
  - Write accepted if SaidaValida=0 or SaidaAceita=1 in the same cycle: PortaSaida<=DadoEscrito, SaidaValida<=1, Pronto=1.
  - Otherwise Pronto=0 and nothing is latched.
  - Read returns PortaSaida, Pronto=1.
- Output handshake: SaidaValida&SaidaAceita with no accepted write that cycle -> SaidaValida<=0. SaidaAceita while SaidaValida=0 has no effect.
- Address 0xFD, status:
  - Read returns {6'b0, EntradaCheia, SaidaValida}, Pronto=1.
  - Write is ignored, Pronto=1.
- Address 0xFE, input data:
  - Read with EntradaCheia=1: DadoLido=EntradaBuf, Pronto=1, EntradaCheia<=0 at the edge (pop).
  - Read with EntradaCheia=0: DadoLido=0, Pronto=0 (stall until a byte arrives).
  - Write is ignored, Pronto=1.
- Address 0xFF: reserved; reads return 0, writes are ignored, Pronto=1.
- Input handshake: EntradaValida&EntradaPronta -> EntradaBuf<=PortaEntrada, EntradaCheia<=1.
  - Because EntradaPronta depends only on the register, push and pop can never occur in the same cycle.
  - A byte captured at edge k can be read at 0xFE in cycle k+1.
- No access (MemRead=MemWrite=0): Pronto=1.
- Pronto is combinational from state, address, request lines and I/O flags; it has no combinational path from PortaEntrada.

Test Plan:
- Clear: preload ram[0x10]=0xAA with CLEAR_ON_RESET=1, pulse Reset for 1 cycle.
  - Pronto=0 for exactly 252 cycles after Reset falls.
  - A subsequent read of 0x10 gives 0x00; SaidaValida=0, EntradaPronta=1.
- RAM read/write: write 0x5C to 0x20, then read 0x20 -> DadoLido=0x5C, Pronto=1.
  - Simultaneous read+write of 0x21 (old 0x00, new 0x77) -> DadoLido=0x00 that cycle, 0x77 next.
- Output backpressure: write 0x41 to 0xFC with SaidaAceita=0 -> PortaSaida=0x41, SaidaValida=1.
  - Second write of 0x42 -> Pronto=0 while SaidaAceita=0.
  - Raise SaidaAceita -> same-cycle accept, PortaSaida=0x42, SaidaValida stays 1.
- Input stall: read 0xFE with EntradaCheia=0 -> Pronto=0, DadoLido=0.
  - Producer drives 0x3E with EntradaValida=1 -> the next cycle shows DadoLido=0x3E, Pronto=1.
  - EntradaCheia clears after that edge.
- Status register: with SaidaValida=1 and EntradaCheia=1, read 0xFD -> 0x03; read 0xFF -> 0x00.
  - Write 0x99 to 0xFD -> no state change.
- Reset mid-stall: assert Reset while a 0xFC write is stalled -> SaidaValida=0 and PortaSaida=0 after the edge, and the clear phase restarts.
